// File: rtl/tut4_verilog_sort_merge_pkg.sv
// rtl/tut4_verilog_sort_merge_pkg.sv - shared state encoding and tie-break rule for the sort merge unit
package tut4_verilog_sort_merge_pkg;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_MERGE  = 2'd0;
   localparam logic [1:0] ST_DRAIN0 = 2'd1;
   localparam logic [1:0] ST_DRAIN1 = 2'd2;

   // Equal keys are taken from stream 0 first so the merge is stable.
   localparam bit TIE_TAKES_IN0 = 1'b1;

endpackage

// File: rtl/tut4_verilog_sort_merge_out_reg.sv
// rtl/tut4_verilog_sort_merge_out_reg.sv - single-entry val/rdy pipeline register carrying {last, msg}
module tut4_verilog_sort_merge_out_reg #(
   parameter int p_nbits = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enq_val,
   input  logic [p_nbits-1:0] enq_msg,
   input  logic               enq_last,
   output logic               deq_val,
   input  logic               deq_rdy,
   output logic [p_nbits-1:0] deq_msg,
   output logic               deq_last,
   output logic               space
);

   // The entry frees up in the same cycle it is dequeued, so a new element can
   // be written behind it without a bubble.
   assign space = !deq_val || deq_rdy;

   // Load a new element when there is room; otherwise hold msg/last stable.
   always_ff @(posedge clk) begin
      if (!reset) begin
         deq_val  <= 1'b0;
         deq_msg  <= '0;
         deq_last <= 1'b0;
      end else if (space) begin
         deq_val <= enq_val;
         if (enq_val) begin
            deq_msg  <= enq_msg;
            deq_last <= enq_last;
         end
      end
   end

endmodule

// File: rtl/tut4_verilog_sort_merge_unit.sv
// rtl/tut4_verilog_sort_merge_unit.sv - merges two ascending sorted runs into one ascending run
module tut4_verilog_sort_merge_unit
   import tut4_verilog_sort_merge_pkg::*;
#(
   parameter int p_nbits     = 32,
   parameter int p_cnt_nbits = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in0_val,
   output logic                   in0_rdy,
   input  logic [p_nbits-1:0]     in0_msg,
   input  logic                   in0_last,
   input  logic                   in1_val,
   output logic                   in1_rdy,
   input  logic [p_nbits-1:0]     in1_msg,
   input  logic                   in1_last,
   output logic                   out_val,
   input  logic                   out_rdy,
   output logic [p_nbits-1:0]     out_msg,
   output logic                   out_last,
   output logic [p_cnt_nbits-1:0] run_count
);

   localparam logic [p_cnt_nbits-1:0] cnt_one = {{(p_cnt_nbits-1){1'b0}}, 1'b1};

   state_t             state;
   state_t             state_next;
   logic               space;
   logic               take0;
   logic               enq_val;
   logic [p_nbits-1:0] enq_msg;
   logic               enq_last;

   assign take0 = (in0_msg < in1_msg) || (TIE_TAKES_IN0 && (in0_msg == in1_msg));

   // Pick at most one input per cycle and decide the next merge phase.
   always_comb begin
      in0_rdy    = 1'b0;
      in1_rdy    = 1'b0;
      enq_val    = 1'b0;
      enq_msg    = '0;
      enq_last   = 1'b0;
      state_next = state;
      if (reset && space) begin
         case (state)
            ST_MERGE: begin
               // Both heads are needed before the comparison means anything.
               if (in0_val && in1_val) begin
                  enq_val = 1'b1;
                  if (take0) begin
                     in0_rdy = 1'b1;
                     enq_msg = in0_msg;
                     if (in0_last) state_next = ST_DRAIN1;
                  end else begin
                     in1_rdy = 1'b1;
                     enq_msg = in1_msg;
                     if (in1_last) state_next = ST_DRAIN0;
                  end
               end
            end
            ST_DRAIN0: begin
               if (in0_val) begin
                  in0_rdy  = 1'b1;
                  enq_val  = 1'b1;
                  enq_msg  = in0_msg;
                  enq_last = in0_last;
                  if (in0_last) state_next = ST_MERGE;
               end
            end
            ST_DRAIN1: begin
               if (in1_val) begin
                  in1_rdy  = 1'b1;
                  enq_val  = 1'b1;
                  enq_msg  = in1_msg;
                  enq_last = in1_last;
                  if (in1_last) state_next = ST_MERGE;
               end
            end
            default: state_next = ST_MERGE;
         endcase
      end
   end

   // Merge phase register; reset drops any partially merged run.
   always_ff @(posedge clk) begin
      if (!reset) state <= ST_MERGE;
      else        state <= state_next;
   end

   // Count runs as their last element enters the output register.
   always_ff @(posedge clk) begin
      if (!reset)                    run_count <= '0;
      else if (enq_val && enq_last)  run_count <= run_count + cnt_one;
   end

   tut4_verilog_sort_merge_out_reg #(
      .p_nbits (p_nbits)
   ) out_reg (
      .clk      (clk),
      .reset    (reset),
      .enq_val  (enq_val),
      .enq_msg  (enq_msg),
      .enq_last (enq_last),
      .deq_val  (out_val),
      .deq_rdy  (out_rdy),
      .deq_msg  (out_msg),
      .deq_last (out_last),
      .space    (space)
   );

`ifndef SYNTHESIS
   function automatic string line_trace();
      string st;
      case (state)
         ST_MERGE:  st = "M ";
         ST_DRAIN0: st = "D0";
         ST_DRAIN1: st = "D1";
         default:   st = "??";
      endcase
      return $sformatf("%s%0d%s | %s%0d%s | %s | %s%0d%s",
                       (in0_val && in0_rdy) ? "*" : " ", in0_msg, in0_last ? "L" : " ",
                       (in1_val && in1_rdy) ? "*" : " ", in1_msg, in1_last ? "L" : " ",
                       st,
                       (out_val && out_rdy) ? "*" : " ", out_msg, out_last ? "L" : " ");
   endfunction
`endif

endmodule
